// File: rtl/theta_iter.sv
// Iterative Keccak theta: folds column parities over 5/ROWS_PER_CYCLE cycles, then applies D[x] to all lanes.
// Latency: input accepted at edge T -> out_valid observed high at edge T+N+2 (N = 5/ROWS_PER_CYCLE).
// Backpressure: result held stable in OUT until out_ready; no new input is taken until the FSM is back in IDLE.
module theta_iter #(
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1599:0] state_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1599:0] state_out,
    output logic          busy
);

    localparam int         N    = 5 / ROWS_PER_CYCLE;
    localparam logic [2:0] LAST = 3'(N - 1);

    // Only folds that divide the five rows evenly are supported.
    if (ROWS_PER_CYCLE != 1 && ROWS_PER_CYCLE != 5) begin : g_bad_param
        $error("theta_iter: ROWS_PER_CYCLE must be 1 or 5");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, APPLY, OUT} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [2:0]             cnt;
    logic [1599:0]          lanes_q;
    logic [4:0][63:0]       c_q;
    logic [4:0][63:0]       c_nxt;
    logic [4:0][63:0]       d;
    logic [4:0][4:0][63:0]  row_sel;
    logic [1599:0]          theta_res;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

    for (genvar x = 0; x < 5; x++) begin : g_col
        // A lane contributes this cycle only if its row falls in the current window.
        for (genvar y = 0; y < 5; y++) begin : g_row
            assign row_sel[x][y] = ((y / ROWS_PER_CYCLE) == int'(cnt))
                                 ? lanes_q[64*(5*x+y) +: 64] : 64'd0;
        end
        assign c_nxt[x] = c_q[x] ^ row_sel[x][0] ^ row_sel[x][1] ^ row_sel[x][2]
                                 ^ row_sel[x][3] ^ row_sel[x][4];
        // ROT by one: bit z takes bit z-1, so bit 63 wraps to bit 0.
        assign d[x] = c_q[(x+4)%5] ^ {c_q[(x+1)%5][62:0], c_q[(x+1)%5][63]};
        for (genvar y = 0; y < 5; y++) begin : g_apply
            assign theta_res[64*(5*x+y) +: 64] = lanes_q[64*(5*x+y) +: 64] ^ d[x];
        end
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ACCUM;
            ACCUM:   if (cnt == LAST) state_nxt = APPLY;
            APPLY:   state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Parity accumulation, row counter and the registered theta result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            c_q       <= '0;
            state_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        c_q <= '0;
                        cnt <= '0;
                    end
                end
                ACCUM: begin
                    c_q <= c_nxt;
                    cnt <= (cnt == LAST) ? 3'd0 : cnt + 3'd1;
                end
                APPLY:   state_out <= theta_res;
                default: ;
            endcase
        end
    end

    // Input buffer; only written on an accepted handshake, so needs no reset.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) lanes_q <= state_in;
    end

endmodule

// File: tb/tb_theta_iter.sv
// Bench for theta_iter: instances with ROWS_PER_CYCLE=1 and =5 driven from shared reset.
// Outputs sampled on the falling edge; inputs changed on the falling edge.
// Results compared against a bit-level theta model.
module tb_theta_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [1:0]           in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0][1599:0]   state_in, state_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    theta_iter #(.ROWS_PER_CYCLE(1)) u_r1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .state_in(state_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .state_out(state_out[0]),
        .busy(busy[0])
    );

    theta_iter #(.ROWS_PER_CYCLE(5)) u_r5 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .state_in(state_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .state_out(state_out[1]),
        .busy(busy[1])
    );

    // Accumulation cycles for each instance.
    function automatic int n_acc(input int i);
        return (i == 0) ? 5 : 1;
    endfunction

    task automatic chk(input string tag, input logic [1599:0] got, input logic [1599:0] exp);
        n_cmp++;
        if (got !== exp) begin
            int l = 0;
            for (int k = 24; k >= 0; k--) if (got[64*k +: 64] !== exp[64*k +: 64]) l = k;
            n_bad++;
            $display("FAIL %s: lane %0d actual=%h required=%h", tag, l, got[64*l +: 64], exp[64*l +: 64]);
        end
    endtask

    // Theta straight from its definition, one bit at a time.
    function automatic logic [1599:0] theta_model(input logic [1599:0] s);
        logic [4:0][63:0] c;
        logic [1599:0]    r;
        for (int x = 0; x < 5; x++)
            for (int z = 0; z < 64; z++) begin
                c[x][z] = 1'b0;
                for (int y = 0; y < 5; y++) c[x][z] = c[x][z] ^ s[64*(5*x+y)+z];
            end
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < 64; z++)
                    r[64*(5*x+y)+z] = s[64*(5*x+y)+z] ^ c[(x+4)%5][z] ^ c[(x+1)%5][(z+63)%64];
        return r;
    endfunction

    function automatic logic [1599:0] rand_state();
        logic [1599:0] r;
        for (int k = 0; k < 50; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [1599:0] single_bit_expect();
        int            bits [11] = '{0, 320, 384, 448, 512, 576, 1281, 1345, 1409, 1473, 1537};
        logic [1599:0] r = '0;
        for (int k = 0; k < 11; k++) r[bits[k]] = 1'b1;
        return r;
    endfunction

    task automatic run_one(input int i, input logic [1599:0] data, input string tag);
        int k;
        int g;
        @(negedge clk);
        state_in[i]  = data;
        in_valid[i]  = 1'b1;
        out_ready[i] = 1'b1;
        g = 0;
        while (!in_ready[i] && g < 50) begin @(negedge clk); g++; end
        chk({tag, "_rdy"}, in_ready[i], 1);
        @(negedge clk);
        in_valid[i] = 1'b0;
        state_in[i] = rand_state();
        k = 0;
        while (!out_valid[i] && k < 50) begin @(negedge clk); k++; end
        chk({tag, "_lat"}, k, n_acc(i) + 1);
        chk({tag, "_out"}, state_out[i], theta_model(data));
        @(negedge clk);
        chk({tag, "_vdrop"}, out_valid[i], 0);
        chk({tag, "_rdy2"}, in_ready[i], 1);
        out_ready[i] = 1'b0;
    endtask

    task automatic backpressure(input int i);
        logic [1599:0] data;
        logic [1599:0] exp;
        int            g;
        data = rand_state();
        exp  = theta_model(data);
        @(negedge clk);
        state_in[i]  = data;
        in_valid[i]  = 1'b1;
        out_ready[i] = 1'b0;
        g = 0;
        while (!in_ready[i] && g < 50) begin @(negedge clk); g++; end
        @(negedge clk);
        state_in[i] = rand_state();
        g = 0;
        while (!out_valid[i] && g < 50) begin @(negedge clk); g++; end
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid", out_valid[i], 1);
            chk("bp_inrdy", in_ready[i], 0);
            chk("bp_data", state_out[i], exp);
            @(negedge clk);
        end
        out_ready[i] = 1'b1;
        @(negedge clk);
        chk("bp_vdrop", out_valid[i], 0);
        chk("bp_rdy", in_ready[i], 1);
        chk("bp_nocap", busy[i], 0);
        chk("bp_hold", state_out[i], exp);
        in_valid[i]  = 1'b0;
        out_ready[i] = 1'b0;
    endtask

    task automatic mid_reset();
        int g;
        @(negedge clk);
        state_in[0]  = rand_state();
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        g = 0;
        while (!in_ready[0] && g < 50) begin @(negedge clk); g++; end
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mr_busy", busy[0], 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_valid", out_valid[0], 0);
        chk("mr_idle", busy[0], 0);
        chk("mr_rdy_in_rst", in_ready[0], 0);
        chk("mr_out_clr", state_out[0], '0);
        rst = 1'b0;
        #1;
        chk("mr_rdy", in_ready[0], 1);
        run_one(0, 1600'd1, "mr_single");
        chk("mr_single_bits", state_out[0], single_bit_expect());
    endtask

    task automatic back_to_back(input int i);
        logic [1599:0] a;
        logic [1599:0] b;
        int            acc [$];
        logic [1599:0] outs [$];
        int            g;
        a = rand_state();
        b = rand_state();
        @(negedge clk);
        out_ready[i] = 1'b1;
        g = 0;
        while (outs.size() < 2 && g < 100) begin
            if (acc.size() == 0) begin state_in[i] = a; in_valid[i] = 1'b1; end
            else if (acc.size() == 1) begin state_in[i] = b; in_valid[i] = 1'b1; end
            else in_valid[i] = 1'b0;
            #1;
            if (in_valid[i] && in_ready[i]) acc.push_back(cyc);
            if (out_valid[i]) outs.push_back(state_out[i]);
            @(negedge clk);
            g++;
        end
        in_valid[i] = 1'b0;
        @(negedge clk);
        out_ready[i] = 1'b0;
        chk("b2b_accepts", acc.size(), 2);
        chk("b2b_outputs", outs.size(), 2);
        if (acc.size() >= 2) chk("b2b_ii", acc[1] - acc[0], n_acc(i) + 3);
        if (outs.size() >= 2) begin
            chk("b2b_out0", outs[0], theta_model(a));
            chk("b2b_out1", outs[1], theta_model(b));
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        state_in  = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_inrdy", in_ready[i], 0);
            chk("rst_valid", out_valid[i], 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_out", state_out[i], '0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_rdy0", in_ready[0], 1);
        chk("post_rst_rdy1", in_ready[1], 1);

        for (int i = 0; i < 2; i++) begin
            run_one(i, '0, "zero");
            chk("zero_bits", state_out[i], '0);
            run_one(i, 1600'd1, "single");
            chk("single_bits", state_out[i], single_bit_expect());
            run_one(i, '1, "ones");
            chk("ones_bits", state_out[i], '1);
            for (int t = 0; t < 4; t++) run_one(i, rand_state(), "rand");
        end

        backpressure(0);
        backpressure(1);
        mid_reset();
        back_to_back(0);
        back_to_back(1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
